// File: rtl/cp0_intc.sv
// Coprocessor-0 interrupt controller: SR/Cause/EPC/PrID registers, hardware
// interrupt sampling and a single qualified interrupt request to the pipeline.
module cp0_intc #(
    parameter logic [31:0] PRID = 32'h0000_2015,
    parameter int          NHW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      A1,
    input  logic [4:0]      A2,
    input  logic [31:0]     Din,
    input  logic            We,
    input  logic [29:0]     PC,
    input  logic [NHW-1:0]  HWInt,
    input  logic            EXLSet,
    input  logic            EXLClr,
    output logic            IntReq,
    output logic [29:0]     EPC,
    output logic [31:0]     Dout
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [NHW-1:0] im_q, im_d;
    logic [NHW-1:0] ip_q, ip_d;
    logic           exl_q, exl_d;
    logic           ie_q, ie_d;
    logic [29:0]    epc_q, epc_d;
    logic           sr_wr_s;
    logic           epc_wr_s;

    assign sr_wr_s  = We && (A2 == REG_SR);
    assign epc_wr_s = We && (A2 == REG_EPC);

    // Next-state selection; exception entry/exit outrank software writes.
    always_comb begin
        ip_d = HWInt;
        im_d = sr_wr_s ? Din[15:10] : im_q;
        ie_d = sr_wr_s ? Din[0]     : ie_q;

        if (EXLSet) begin
            exl_d = 1'b1;
        end else if (EXLClr) begin
            exl_d = 1'b0;
        end else if (sr_wr_s) begin
            exl_d = Din[1];
        end else begin
            exl_d = exl_q;
        end

        if (EXLSet) begin
            epc_d = PC;
        end else if (epc_wr_s) begin
            epc_d = Din[31:2];
        end else begin
            epc_d = epc_q;
        end
    end

    // State registers with synchronous reset taking precedence over all events.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= {NHW{1'b0}};
            ip_q  <= {NHW{1'b0}};
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            epc_q <= 30'd0;
        end else begin
            im_q  <= im_d;
            ip_q  <= ip_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            epc_q <= epc_d;
        end
    end

    // Request is held off while an exception is being serviced.
    assign IntReq = (|(ip_q & im_q)) & ie_q & ~exl_q;
    assign EPC    = epc_q;

    // mfc0 read mux; unmapped registers read as zero.
    always_comb begin
        Dout = 32'd0;
        case (A1)
            REG_SR:    Dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
            REG_CAUSE: Dout = {16'd0, ip_q, 10'd0};
            REG_EPC:   Dout = {epc_q, 2'b00};
            REG_PRID:  Dout = PRID;
            default:   Dout = 32'd0;
        endcase
    end

endmodule
